pci_target: RTL and testbench
=============================

Name: pci_target

Overview:
- PCI target (responder) for single-word and burst memory read/write transactions started by a PCI initiator on the shared bus.
- Decodes the address phase and claims the transaction with DEVSEL.
- Serves data phases from a small local register file, using TRDY/STOP.
- Bus pins are split into in/out/output-enable triplets; tristate resolution happens at the top level.

Parameters:
- DEVICE_ID, 2'b00: value matched against AD[31:30] in the address phase.
- DEPTH, 10: number of 32-bit memory words; legal range 1..16.

Ports:
- CLK  input  1  PCI clock; all logic on posedge.
- RST  input  1  asynchronous, active-high reset.
- FRAME  input  1  active-low; initiator frame.
- IRDY  input  1  active-low; initiator ready.
- CBE  input  4  command in the address phase; active-low byte enables in data phases.
- AD_IN  input  32  sampled AD bus.
- AD_OUT  output  32  read data.
- AD_OE  output  1  AD drive enable.
- TRDY  output  1  active-low target ready.
- DEVSEL  output  1  active-low device select.
- STOP  output  1  active-low target disconnect.
- TRDY_OE  output  1  common drive enable for TRDY, DEVSEL and STOP.

Behaviour:
- Reset (asynchronous, from RST):
  - IDLE state; TRDY=DEVSEL=STOP=1; AD_OE=TRDY_OE=0; AD_OUT=0.
  - All memory words cleared to 0.
  - RST asserted mid-transaction releases all outputs immediately.
- Data transfer occurs on a posedge where IRDY=0 and TRDY=0.
- Address phase is a posedge in IDLE with FRAME=0. It is a hit only if all hold:
  - AD[31:30]==DEVICE_ID;
  - AD[1:0]==00;
  - AD[5:2]<DEPTH;
  - CBE==4'b0110 (mem read) or 4'b0111 (mem write).
  - On hit: latch index=AD[5:2], latch cmd, go to CLAIM.
  - On miss: go to BUSY.
- BUSY: outputs released. Return to IDLE on a posedge with FRAME=1 and IRDY=1.
- CLAIM (one cycle after the address phase): TRDY_OE=1, DEVSEL=0.
  - Write: TRDY=0 in this same cycle; go to DATA.
  - Read: TRDY=1 for the AD turnaround cycle; go to DATA. AD_OE=1 from the following cycle.
- DATA: DEVSEL=0, TRDY=0; on reads AD_OE=1 and AD_OUT=mem[index] (combinational from the current index).
  - Write transfer: mem[index] is updated per byte lane; lane k is written only where CBE[k]=0.
  - Any transfer increments index by 1.
  - index==DEPTH-1 in DATA: STOP=0 (disconnect with data). Once STOP is asserted, no further transfers occur; TRDY=1 after the transfer at DEPTH-1.
  - Transfer with FRAME=1 (last data phase): go to TURN.
  - While STOP=0, wait for FRAME=1, then go to TURN.
  - IRDY=1 in DATA: wait state; hold all outputs and index.
- TURN (one cycle):
  - TRDY=DEVSEL=STOP=1 driven high; TRDY_OE=1, AD_OE=0.
  - Next cycle TRDY_OE=0 and state returns to IDLE.
  - An address phase is not recognised during TURN.
- Index never wraps; writes beyond DEPTH-1 are impossible.
- Latencies:
  - Write: first transfer can complete at address phase +1.
  - Read: first transfer can complete at address phase +2.

Optional Feature:
- Macro: PARITY_EN.
- Defined: adds the following ports.
  - PAR_OUT and PAR_OE outputs: even parity over AD_OUT and CBE, registered, valid one cycle after each cycle with AD_OE=1. PAR_OE is AD_OE delayed by one cycle.
  - PAR_IN input.
  - PERR output: active-low, reset 1. Pulses 0 for one cycle two clocks after a write transfer whose ^{AD_IN,CBE,PAR_IN} computed one clock later is 1.
- Undefined: none of these ports or logic exist.

Test Plan:
- Write, then read back:
  - Write: address 0x0000_0010, CBE=0111, data 0xDEADBEEF, CBE=0000, FRAME released with IRDY=0 -> DEVSEL and TRDY low at address phase +1; mem[4]=0xDEADBEEF.
  - Read: same address, CBE=0110 -> TRDY high at +1, low at +2; AD_OUT=0xDEADBEEF with AD_OE=1.
- Byte-enable write: mem[2]=0x11223344, then write 0xAABBCCDD with CBE=1010 -> mem[2]=0x11BB33DD.
- Burst read disconnect: read burst from address 0x20 (index 8) with FRAME held low -> transfers of mem[8], mem[9]; STOP=0 with the index-9 transfer, TRDY=1 afterwards; on FRAME=1 enter TURN; TRDY_OE=0 one cycle later.
- Miss cases -> DEVSEL stays 1, TRDY_OE=0, and the next transaction after FRAME/IRDY go idle is accepted normally:
  - AD[31:30]=01 with DEVICE_ID=00;
  - address 0x28 (index 10);
  - CBE=0010.
- IRDY wait states: write burst with IRDY=1 for 3 cycles between data phases -> index and memory unchanged during the waits; 3-word burst lands in consecutive words.
- Reset mid-burst: assert RST during DATA -> TRDY, DEVSEL, STOP=1 and OEs=0 without a clock edge; memory reads back 0 afterwards.

Source files
------------

// File: rtl/pci_target_if.sv
// PCI target bus bundle: initiator-driven pins plus target outputs as in/out/oe triplets.
// Parity pins exist only when PARITY_EN is defined.
interface pci_target_if;
    logic        FRAME;
    logic        IRDY;
    logic [3:0]  CBE;
    logic [31:0] AD_IN;
    logic [31:0] AD_OUT;
    logic        AD_OE;
    logic        TRDY;
    logic        DEVSEL;
    logic        STOP;
    logic        TRDY_OE;
`ifdef PARITY_EN
    logic        PAR_IN;
    logic        PAR_OUT;
    logic        PAR_OE;
    logic        PERR;

    modport master (
        output FRAME, IRDY, CBE, AD_IN, PAR_IN,
        input  AD_OUT, AD_OE, TRDY, DEVSEL, STOP, TRDY_OE, PAR_OUT, PAR_OE, PERR
    );
    modport slave (
        input  FRAME, IRDY, CBE, AD_IN, PAR_IN,
        output AD_OUT, AD_OE, TRDY, DEVSEL, STOP, TRDY_OE, PAR_OUT, PAR_OE, PERR
    );
`else
    modport master (
        output FRAME, IRDY, CBE, AD_IN,
        input  AD_OUT, AD_OE, TRDY, DEVSEL, STOP, TRDY_OE
    );
    modport slave (
        input  FRAME, IRDY, CBE, AD_IN,
        output AD_OUT, AD_OE, TRDY, DEVSEL, STOP, TRDY_OE
    );
`endif
endinterface

// File: rtl/pci_target.sv
// PCI memory target over a DEPTH-word register file; optional parity via PARITY_EN.
// Latency: write data phase completes at address+1, read at address+2.
// Backpressure: IRDY high inserts wait states; STOP disconnects with data at the last word.
module pci_target #(
    parameter logic [1:0] DEVICE_ID = 2'b00,
    parameter int         DEPTH     = 10
) (
    input  logic       CLK,
    input  logic       RST,
    pci_target_if.slave bus
);
    typedef enum logic [2:0] {IDLE, BUSY, CLAIM, DATA, DISC, TURN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx;
    logic        cmd_wr;
    logic [31:0] mem [DEPTH];

    logic        addr_hit, data_act, xfer, at_last;
    logic        trdy, devsel, stop, trdy_oe, ad_oe;
    logic [31:0] ad_out;

    assign addr_hit = (bus.AD_IN[31:30] == DEVICE_ID) &&
                      (bus.AD_IN[1:0] == 2'b00) &&
                      ({1'b0, bus.AD_IN[5:2]} < 5'(DEPTH)) &&
                      ((bus.CBE == 4'b0110) || (bus.CBE == 4'b0111));

    // A write claim already asserts TRDY, so it behaves as the first data phase.
    assign data_act = (state == DATA) || ((state == CLAIM) && cmd_wr);
    assign xfer     = data_act && !bus.IRDY;
    assign at_last  = (idx == 4'(DEPTH - 1));

    always_comb begin
        state_nxt = state;
        trdy      = 1'b1;
        devsel    = 1'b1;
        stop      = 1'b1;
        trdy_oe   = 1'b0;
        ad_oe     = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.FRAME)
                    state_nxt = addr_hit ? CLAIM : BUSY;
            end
            BUSY: begin
                if (bus.FRAME && bus.IRDY)
                    state_nxt = IDLE;
            end
            CLAIM, DATA: begin
                trdy_oe   = 1'b1;
                devsel    = 1'b0;
                state_nxt = DATA;
                if (data_act) begin
                    trdy  = 1'b0;
                    stop  = !at_last;
                    ad_oe = !cmd_wr;
                    if (xfer)
                        state_nxt = bus.FRAME ? TURN : (at_last ? DISC : DATA);
                end
            end
            DISC: begin
                // Last word already moved; hold STOP until the initiator drops FRAME.
                trdy_oe = 1'b1;
                devsel  = 1'b0;
                stop    = 1'b0;
                ad_oe   = !cmd_wr;
                if (bus.FRAME)
                    state_nxt = TURN;
            end
            TURN: begin
                trdy_oe   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            idx    <= 4'd0;
            cmd_wr <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 32'd0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && !bus.FRAME && addr_hit) begin
                idx    <= bus.AD_IN[5:2];
                cmd_wr <= bus.CBE[0];
            end else if (xfer) begin
                if (cmd_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (!bus.CBE[b])
                            mem[idx][8*b +: 8] <= bus.AD_IN[8*b +: 8];
                end
                // The index parks on the last word instead of wrapping.
                if (!at_last)
                    idx <= idx + 4'd1;
            end
        end
    end

    assign ad_out      = ad_oe ? mem[idx] : 32'd0;
    assign bus.AD_OUT  = ad_out;
    assign bus.AD_OE   = ad_oe;
    assign bus.TRDY    = trdy;
    assign bus.DEVSEL  = devsel;
    assign bus.STOP    = stop;
    assign bus.TRDY_OE = trdy_oe;

`ifdef PARITY_EN
    logic par_q, par_oe_q, wr_pend, wr_xor, perr_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_q    <= 1'b0;
            par_oe_q <= 1'b0;
            wr_pend  <= 1'b0;
            wr_xor   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            par_q    <= ^{ad_out, bus.CBE};
            par_oe_q <= ad_oe;
            // PAR trails its data phase by a clock, so fold it in one cycle late.
            wr_pend  <= xfer && cmd_wr;
            wr_xor   <= ^{bus.AD_IN, bus.CBE};
            perr_q   <= wr_pend && (wr_xor ^ bus.PAR_IN);
        end
    end

    assign bus.PAR_OUT = par_q;
    assign bus.PAR_OE  = par_oe_q;
    assign bus.PERR    = !perr_q;
`endif
endmodule

// File: tb/tb_pci_target.sv
// Random and directed PCI initiator driving pci_target, checked against a word-array memory model.
module tb_pci_target;
    localparam int         DEPTH = 10;
    localparam logic [1:0] DEV   = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pci_target_if bus();

    pci_target #(.DEVICE_ID(DEV), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [31:0] mdl [DEPTH];
    logic [31:0] wdata [8];
    logic [3:0]  wbe [8];
    int          wcnt [8];
    logic [31:0] last_rd;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_released(input string tag);
        chk({tag, "_trdy"}, bus.TRDY, 1);
        chk({tag, "_devsel"}, bus.DEVSEL, 1);
        chk({tag, "_stop"}, bus.STOP, 1);
        chk({tag, "_ad_oe"}, bus.AD_OE, 0);
        chk({tag, "_trdy_oe"}, bus.TRDY_OE, 0);
    endtask

    task automatic clear_phase_cfg();
        for (int i = 0; i < 8; i++) begin
            wdata[i] = $urandom;
            wbe[i]   = 4'h0;
            wcnt[i]  = 0;
        end
    endtask

    // One initiator transaction; expectations follow the protocol rules, not DUT state.
    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] addr, input int nw);
        bit hit, wr, done, after_last;
        int k, idx, wleft;
        hit = (addr[31:30] == DEV) && (addr[1:0] == 2'b00) && (int'(addr[5:2]) < DEPTH) &&
              ((cmd == 4'b0110) || (cmd == 4'b0111));
        wr  = cmd[0];
        @(posedge clk); #1;
        bus.FRAME = 1'b0; bus.IRDY = 1'b1; bus.AD_IN = addr; bus.CBE = cmd;
        @(posedge clk); #1;
        if (!hit) begin
            for (int c = 1; c <= 3; c++) begin
                bus.IRDY = 1'b0; bus.AD_IN = $urandom; bus.CBE = 4'h0;
                @(negedge clk);
                chk("miss_devsel", bus.DEVSEL, 1);
                chk("miss_trdy_oe", bus.TRDY_OE, 0);
                @(posedge clk); #1;
            end
            bus.FRAME = 1'b1; bus.IRDY = 1'b1;
            @(posedge clk); #1;
        end else begin
            k = 0; idx = int'(addr[5:2]); wleft = wcnt[0]; after_last = 0; done = 0;
            for (int c = 1; c <= 80 && !done; c++) begin
                if (after_last) begin
                    bus.FRAME = 1'b1; bus.IRDY = 1'b1;
                end else if (wleft > 0) begin
                    bus.IRDY = 1'b1; bus.FRAME = 1'b0; wleft--;
                end else begin
                    bus.IRDY = 1'b0; bus.FRAME = (k == nw - 1);
                    bus.AD_IN = wdata[k]; bus.CBE = wbe[k];
                end
                @(negedge clk);
                if (c == 1) begin
                    chk("claim_devsel", bus.DEVSEL, 0);
                    chk("claim_trdy", bus.TRDY, wr ? 0 : 1);
                end else if (!after_last) begin
                    chk("data_trdy", bus.TRDY, 0);
                end
                if (after_last) begin
                    chk("disc_trdy", bus.TRDY, 1);
                    chk("disc_stop", bus.STOP, 0);
                    done = 1;
                end else if (!bus.TRDY) begin
                    chk("stop", bus.STOP, (idx == DEPTH - 1) ? 0 : 1);
                end
                if (!bus.TRDY && !bus.IRDY && !after_last) begin
                    if (wr) begin
                        for (int b = 0; b < 4; b++)
                            if (!wbe[k][b]) mdl[idx][8*b +: 8] = wdata[k][8*b +: 8];
                    end else begin
                        last_rd = bus.AD_OUT;
                        chk("rd_data", bus.AD_OUT, mdl[idx]);
                        chk("rd_oe", bus.AD_OE, 1);
                    end
                    if (bus.FRAME) done = 1;
                    else if (idx == DEPTH - 1) after_last = 1;
                    idx++; k++;
                    if (k < 8) wleft = wcnt[k];
                end
                @(posedge clk); #1;
            end
            if (!done) chk("timeout", 0, 1);
            bus.FRAME = 1'b1; bus.IRDY = 1'b1;
            @(negedge clk);
            chk("turn_trdy_oe", bus.TRDY_OE, 1);
            chk("turn_devsel", bus.DEVSEL, 1);
            chk("turn_trdy", bus.TRDY, 1);
            chk("turn_stop", bus.STOP, 1);
            chk("turn_ad_oe", bus.AD_OE, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle_trdy_oe", bus.TRDY_OE, 0);
        end
    endtask

`ifdef PARITY_EN
    initial bus.PAR_IN = 1'b0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  cmd;
        logic [31:0] addr;
        bus.FRAME = 1'b1; bus.IRDY = 1'b1; bus.AD_IN = 32'd0; bus.CBE = 4'h0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
        last_rd = 32'd0;
        clear_phase_cfg();
        #1;
        check_released("reset");
        chk("reset_ad_out", bus.AD_OUT, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // write then read back one word
        clear_phase_cfg();
        wdata[0] = 32'hDEADBEEF;
        run_txn(4'b0111, 32'h0000_0010, 1);
        run_txn(4'b0110, 32'h0000_0010, 1);
        chk("wr_rd_back", last_rd, 32'hDEADBEEF);

        // byte-lane merge
        clear_phase_cfg();
        wdata[0] = 32'h11223344;
        run_txn(4'b0111, 32'h0000_0008, 1);
        wdata[0] = 32'hAABBCCDD; wbe[0] = 4'b1010;
        run_txn(4'b0111, 32'h0000_0008, 1);
        run_txn(4'b0110, 32'h0000_0008, 1);
        chk("be_merge", last_rd, 32'h11BB33DD);

        // burst read running into the disconnect at the top word
        clear_phase_cfg();
        run_txn(4'b0110, 32'h0000_0020, 4);

        // misses, each followed by a normal hit
        clear_phase_cfg();
        run_txn(4'b0110, 32'h4000_0010, 1);
        run_txn(4'b0110, 32'h0000_0028, 1);
        run_txn(4'b0010, 32'h0000_0010, 1);
        run_txn(4'b0110, 32'h0000_0010, 1);
        chk("after_miss_rd", last_rd, 32'hDEADBEEF);

        // write burst with initiator wait states, then read it back
        clear_phase_cfg();
        wcnt[1] = 3; wcnt[2] = 3;
        run_txn(4'b0111, 32'h0000_0004, 3);
        clear_phase_cfg();
        run_txn(4'b0110, 32'h0000_0004, 3);
        chk("wait_burst_w3", last_rd, mdl[3]);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            clear_phase_cfg();
            for (int i = 0; i < 8; i++) begin
                wbe[i]  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                wcnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            cmd  = ($urandom_range(0, 9) == 0) ? 4'($urandom) :
                   (($urandom_range(0, 1) == 1) ? 4'b0111 : 4'b0110);
            addr = $urandom;
            addr[31:30] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : DEV;
            addr[1:0]   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            addr[5:2]   = 4'($urandom_range(0, 11));
            run_txn(cmd, addr, $urandom_range(1, 5));
        end

        // reset in the middle of a write burst
        @(posedge clk); #1;
        bus.FRAME = 1'b0; bus.IRDY = 1'b1; bus.AD_IN = 32'h0000_0004; bus.CBE = 4'b0111;
        @(posedge clk); #1;
        bus.IRDY = 1'b0; bus.AD_IN = 32'h5555_AAAA; bus.CBE = 4'h0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_devsel", bus.DEVSEL, 0);
        #2 rst = 1'b1;
        #1;
        check_released("mid_rst");
        bus.FRAME = 1'b1; bus.IRDY = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
        clear_phase_cfg();
        run_txn(4'b0110, 32'h0000_0000, DEPTH);
        chk("post_rst_last", last_rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
